cache_way_ctrl: RTL and testbench

Way-sequencing controller for the 4-way set-associative write-back/write-allocate cache. It takes one CPU access at a time, resolves hit or miss from the tag comparators, and picks the target way: the hit way, else the first invalid way, else the tree-PLRU victim. On a miss it runs the dirty-victim write-back and refill handshakes with memory. It drives the 2-bit way select and the write enable into the cache's 1-to-4 way-write demultiplexer, and it keeps the per-set PLRU state.

---
 rtl/cache_way_ctrl.sv | 159 +++++++++++++++
 tb/tb_cache_way_ctrl.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/cache_way_ctrl.sv
// Way-sequencing controller for a 4-way write-back/write-allocate cache:
// resolves hit/miss, picks the target way, runs write-back/refill and keeps tree-PLRU state.
module cache_way_ctrl #(
    parameter int SETS    = 64,
    parameter int INDEX_W = 6
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               req_valid,
    input  logic               req_write,
    input  logic [INDEX_W-1:0] req_index,
    input  logic [3:0]         hit_vec,
    input  logic [3:0]         valid_vec,
    input  logic [3:0]         dirty_vec,
    input  logic               mem_ready,
    output logic [1:0]         way_sel,
    output logic               way_we,
    output logic               fill,
    output logic               dirty_set,
    output logic               mem_wr_req,
    output logic               mem_rd_req,
    output logic               req_ready,
    output logic               hit
);

    typedef enum logic [2:0] {
        IDLE,
        LOOKUP,
        WRITEBACK,
        REFILL,
        UPDATE
    } state_t;

    state_t             state;
    logic [INDEX_W-1:0] lat_index;
    logic               lat_write;
    logic [2:0]         plru [SETS];

    logic [2:0] cur_plru;
    logic [1:0] victim;
    logic [1:0] target;
    logic       any_hit;
    logic       any_invalid;

    // Point the tree away from the way just touched; the untouched subtree bit is kept.
    function automatic logic [2:0] plru_next(input logic [2:0] bits, input logic [1:0] w);
        logic [2:0] nb;
        nb = bits;
        unique case (w)
            2'd0: begin nb[0] = 1'b1; nb[1] = 1'b1; end
            2'd1: begin nb[0] = 1'b1; nb[1] = 1'b0; end
            2'd2: begin nb[0] = 1'b0; nb[2] = 1'b1; end
            default: begin nb[0] = 1'b0; nb[2] = 1'b0; end
        endcase
        return nb;
    endfunction

    always_comb begin
        cur_plru    = plru[lat_index];
        victim      = cur_plru[0] ? (cur_plru[2] ? 2'd3 : 2'd2)
                                  : (cur_plru[1] ? 2'd1 : 2'd0);
        any_hit     = |hit_vec;
        any_invalid = ~&valid_vec;
        target      = victim;
        if      (hit_vec[0])    target = 2'd0;
        else if (hit_vec[1])    target = 2'd1;
        else if (hit_vec[2])    target = 2'd2;
        else if (hit_vec[3])    target = 2'd3;
        else if (!valid_vec[0]) target = 2'd0;
        else if (!valid_vec[1]) target = 2'd1;
        else if (!valid_vec[2]) target = 2'd2;
        else if (!valid_vec[3]) target = 2'd3;
    end

    // Strobes default low every cycle and are raised only on the transition into
    // the state that owns them, so every output is a flop.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            lat_index  <= '0;
            lat_write  <= 1'b0;
            way_sel    <= 2'd0;
            way_we     <= 1'b0;
            fill       <= 1'b0;
            dirty_set  <= 1'b0;
            mem_wr_req <= 1'b0;
            mem_rd_req <= 1'b0;
            req_ready  <= 1'b0;
            hit        <= 1'b0;
            for (int s = 0; s < SETS; s++) begin
                plru[s] <= 3'b000;
            end
        end else begin
            way_we     <= 1'b0;
            fill       <= 1'b0;
            dirty_set  <= 1'b0;
            mem_wr_req <= 1'b0;
            mem_rd_req <= 1'b0;
            req_ready  <= 1'b0;
            hit        <= 1'b0;

            unique case (state)
                IDLE: begin
                    if (req_valid) begin
                        lat_index <= req_index;
                        lat_write <= req_write;
                        state     <= LOOKUP;
                    end
                end

                LOOKUP: begin
                    way_sel <= target;
                    if (any_hit) begin
                        state     <= UPDATE;
                        req_ready <= 1'b1;
                        hit       <= 1'b1;
                        way_we    <= lat_write;
                        dirty_set <= lat_write;
                    end else if (!any_invalid && dirty_vec[target]) begin
                        state      <= WRITEBACK;
                        mem_wr_req <= 1'b1;
                    end else begin
                        state      <= REFILL;
                        mem_rd_req <= 1'b1;
                    end
                end

                WRITEBACK: begin
                    if (mem_ready) begin
                        state      <= REFILL;
                        mem_rd_req <= 1'b1;
                    end else begin
                        mem_wr_req <= 1'b1;
                    end
                end

                REFILL: begin
                    if (mem_ready) begin
                        state     <= UPDATE;
                        req_ready <= 1'b1;
                        way_we    <= 1'b1;
                        fill      <= 1'b1;
                        dirty_set <= lat_write;
                    end else begin
                        mem_rd_req <= 1'b1;
                    end
                end

                UPDATE: begin
                    plru[lat_index] <= plru_next(plru[lat_index], way_sel);
                    state           <= IDLE;
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cache_way_ctrl.sv
// Directed self-checking bench for cache_way_ctrl: hits, clean/dirty misses,
// PLRU victim choice, back-to-back requests and reset in the middle of a refill.
module tb_cache_way_ctrl;

    logic       clk;
    logic       rst;
    logic       req_valid;
    logic       req_write;
    logic [5:0] req_index;
    logic [3:0] hit_vec;
    logic [3:0] valid_vec;
    logic [3:0] dirty_vec;
    logic       mem_ready;
    logic [1:0] way_sel;
    logic       way_we;
    logic       fill;
    logic       dirty_set;
    logic       mem_wr_req;
    logic       mem_rd_req;
    logic       req_ready;
    logic       hit;

    int comparisons = 0;
    int failures    = 0;

    cache_way_ctrl #(.SETS(64), .INDEX_W(6)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_write  (req_write),
        .req_index  (req_index),
        .hit_vec    (hit_vec),
        .valid_vec  (valid_vec),
        .dirty_vec  (dirty_vec),
        .mem_ready  (mem_ready),
        .way_sel    (way_sel),
        .way_we     (way_we),
        .fill       (fill),
        .dirty_set  (dirty_set),
        .mem_wr_req (mem_wr_req),
        .mem_rd_req (mem_rd_req),
        .req_ready  (req_ready),
        .hit        (hit)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string tag, input logic [7:0] observed, input logic [7:0] expected);
        comparisons++;
        assert (observed === expected)
        else begin
            failures++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic v, input logic w, input logic [5:0] idx,
                                 input logic [3:0] hv, input logic [3:0] vv, input logic [3:0] dv);
        req_valid = v;
        req_write = w;
        req_index = idx;
        hit_vec   = hv;
        valid_vec = vv;
        dirty_vec = dv;
    endtask

    task automatic checkQuiet(input string tag);
        checkOutput({tag, "/req_ready"},  {7'd0, req_ready},  8'd0);
        checkOutput({tag, "/way_we"},     {7'd0, way_we},     8'd0);
        checkOutput({tag, "/fill"},       {7'd0, fill},       8'd0);
        checkOutput({tag, "/dirty_set"},  {7'd0, dirty_set},  8'd0);
        checkOutput({tag, "/mem_wr_req"}, {7'd0, mem_wr_req}, 8'd0);
        checkOutput({tag, "/mem_rd_req"}, {7'd0, mem_rd_req}, 8'd0);
        checkOutput({tag, "/hit"},        {7'd0, hit},        8'd0);
    endtask

    // One complete access starting at a negedge in IDLE; wb/rf are the number of
    // cycles each mem request stays up (wb=0 means no write-back).
    task automatic doAccess(input string tag, input logic w, input logic [5:0] idx,
                            input logic [3:0] hv, input logic [3:0] vv, input logic [3:0] dv,
                            input int wb, input int rf, input logic exp_hit, input logic [1:0] exp_way);
        applyStimulus(1'b1, w, idx, hv, vv, dv);
        @(negedge clk);
        checkOutput({tag, "/lookup_rdy"}, {7'd0, req_ready},  8'd0);
        checkOutput({tag, "/lookup_wr"},  {7'd0, mem_wr_req}, 8'd0);
        checkOutput({tag, "/lookup_rd"},  {7'd0, mem_rd_req}, 8'd0);
        @(negedge clk);
        for (int i = 0; i < wb; i++) begin
            checkOutput({tag, "/wb_wr"},  {7'd0, mem_wr_req}, 8'd1);
            checkOutput({tag, "/wb_rd"},  {7'd0, mem_rd_req}, 8'd0);
            checkOutput({tag, "/wb_way"}, {6'd0, way_sel},    {6'd0, exp_way});
            mem_ready = (i == wb - 1);
            @(negedge clk);
        end
        mem_ready = 1'b0;
        if (!exp_hit) begin
            for (int i = 0; i < rf; i++) begin
                checkOutput({tag, "/rf_rd"},  {7'd0, mem_rd_req}, 8'd1);
                checkOutput({tag, "/rf_wr"},  {7'd0, mem_wr_req}, 8'd0);
                checkOutput({tag, "/rf_rdy"}, {7'd0, req_ready},  8'd0);
                checkOutput({tag, "/rf_way"}, {6'd0, way_sel},    {6'd0, exp_way});
                mem_ready = (i == rf - 1);
                @(negedge clk);
            end
            mem_ready = 1'b0;
        end
        checkOutput({tag, "/upd_rdy"},   {7'd0, req_ready},  8'd1);
        checkOutput({tag, "/upd_hit"},   {7'd0, hit},        {7'd0, exp_hit});
        checkOutput({tag, "/upd_way"},   {6'd0, way_sel},    {6'd0, exp_way});
        checkOutput({tag, "/upd_we"},    {7'd0, way_we},     {7'd0, (w | ~exp_hit)});
        checkOutput({tag, "/upd_fill"},  {7'd0, fill},       {7'd0, ~exp_hit});
        checkOutput({tag, "/upd_dirty"}, {7'd0, dirty_set},  {7'd0, w});
        checkOutput({tag, "/upd_wr"},    {7'd0, mem_wr_req}, 8'd0);
        checkOutput({tag, "/upd_rd"},    {7'd0, mem_rd_req}, 8'd0);
        req_valid = 1'b0;
        @(negedge clk);
        checkQuiet({tag, "/idle"});
    endtask

    initial begin
        rst       = 1'b1;
        mem_ready = 1'b0;
        applyStimulus(1'b0, 1'b0, 6'd0, 4'b0000, 4'b0000, 4'b0000);
        repeat (3) @(negedge clk);
        checkQuiet("reset");
        checkOutput("reset/way_sel", {6'd0, way_sel}, 8'd0);
        rst = 1'b0;
        @(negedge clk);

        // Read hit on way 2 with a stray mem_ready that must be ignored.
        mem_ready = 1'b1;
        doAccess("rd_hit2", 1'b0, 6'd5, 4'b0100, 4'b1111, 4'b0000, 0, 0, 1'b1, 2'd2);
        doAccess("wr_hit0", 1'b1, 6'd5, 4'b0001, 4'b1111, 4'b0000, 0, 0, 1'b1, 2'd0);
        doAccess("hit_prio", 1'b0, 6'd41, 4'b1010, 4'b1111, 4'b0000, 0, 0, 1'b1, 2'd1);

        // Clean miss into the invalid way 2; req_ready lands in cycle 6.
        doAccess("miss_inv2", 1'b0, 6'd9, 4'b0000, 4'b1011, 4'b1111, 0, 4, 1'b0, 2'd2);
        doAccess("miss_inv1", 1'b1, 6'd40, 4'b0000, 4'b1001, 4'b0000, 0, 1, 1'b0, 2'd1);

        // Fresh set, all valid, victim way 0 is dirty.
        doAccess("dirty_v0", 1'b0, 6'd20, 4'b0000, 4'b1111, 4'b0001, 3, 2, 1'b0, 2'd0);

        // Ways 0, 2, 1 touched on set 30 leave way 3 as the PLRU victim.
        doAccess("s30_w0", 1'b0, 6'd30, 4'b0001, 4'b1111, 4'b0000, 0, 0, 1'b1, 2'd0);
        doAccess("s30_w2", 1'b0, 6'd30, 4'b0100, 4'b1111, 4'b0000, 0, 0, 1'b1, 2'd2);
        doAccess("s30_w1", 1'b0, 6'd30, 4'b0010, 4'b1111, 4'b0000, 0, 0, 1'b1, 2'd1);
        doAccess("s30_vic3", 1'b0, 6'd30, 4'b0000, 4'b1111, 4'b0000, 0, 1, 1'b0, 2'd3);

        // Set 5 PLRU is now 3'b111: a dirty write miss evicts way 3.
        doAccess("s5_wmiss", 1'b1, 6'd5, 4'b0000, 4'b1111, 4'b1000, 1, 1, 1'b0, 2'd3);

        // Back-to-back: req_valid still high after req_ready starts a new access.
        applyStimulus(1'b1, 1'b0, 6'd7, 4'b0010, 4'b1111, 4'b0000);
        repeat (2) @(negedge clk);
        checkOutput("b2b/first_rdy", {7'd0, req_ready}, 8'd1);
        checkOutput("b2b/first_way", {6'd0, way_sel}, 8'd1);
        hit_vec = 4'b1000;
        @(negedge clk);
        checkOutput("b2b/idle_rdy", {7'd0, req_ready}, 8'd0);
        @(negedge clk);
        checkOutput("b2b/lookup_rdy", {7'd0, req_ready}, 8'd0);
        @(negedge clk);
        checkOutput("b2b/second_rdy", {7'd0, req_ready}, 8'd1);
        checkOutput("b2b/second_way", {6'd0, way_sel}, 8'd3);
        req_valid = 1'b0;
        @(negedge clk);

        // Reset while refilling: everything drops, the access is abandoned.
        applyStimulus(1'b1, 1'b1, 6'd50, 4'b0000, 4'b0111, 4'b0000);
        repeat (2) @(negedge clk);
        checkOutput("rst_mid/rd_req", {7'd0, mem_rd_req}, 8'd1);
        checkOutput("rst_mid/way", {6'd0, way_sel}, 8'd3);
        rst       = 1'b1;
        req_valid = 1'b0;
        @(negedge clk);
        checkQuiet("rst_mid/after");
        checkOutput("rst_mid/way_sel", {6'd0, way_sel}, 8'd0);
        rst = 1'b0;
        @(negedge clk);
        checkQuiet("rst_mid/still_idle");
        doAccess("post_rst_hit", 1'b0, 6'd50, 4'b1000, 4'b1111, 4'b0000, 0, 0, 1'b1, 2'd3);

        // Reset cleared set 5's PLRU, so the victim falls back to way 0.
        doAccess("post_rst_vic0", 1'b0, 6'd5, 4'b0000, 4'b1111, 4'b0000, 0, 2, 1'b0, 2'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", comparisons, failures);
        $finish;
    end

endmodule
